// File: rtl/elementwise_mac_stream_pkg.sv
// Shared definitions for the elementwise/dot-product MAC stream.
// Holds the mode encodings, the input-side FSM state type and a constant
// clog2 helper used to size lane sums and the accumulator's carry detection.
package elementwise_mac_stream_pkg;

  localparam logic MODE_ELEM = 1'b0;
  localparam logic MODE_DOT  = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elementwise_mac_stream_lane_product_row.sv
// lane_product_row: pipeline stage S1 of the MAC stream.
// Multiplies LANES unsigned WIDTH-bit operand pairs at full precision and
// reduces the products with a balanced adder tree; products, lane sum and the
// beat's valid/last/mode side-band are registered when en_i is high.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        pipeline advance enable
//   valid_i     beat valid entering S1
//   last_i      beat is last of its packet
//   mode_i      packet mode resolved for this beat
//   a_i, b_i    packed lane operands, lane i at [i*WIDTH +: WIDTH]
//   valid_o, last_o, mode_o  registered side-band
//   prod_o      registered products, lane i at [i*2*WIDTH +: 2*WIDTH]
//   sum_o       registered sum of all lane products
module lane_product_row
  import elementwise_mac_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en_i,
  input  logic                               valid_i,
  input  logic                               last_i,
  input  logic                               mode_i,
  input  logic [LANES*WIDTH-1:0]             a_i,
  input  logic [LANES*WIDTH-1:0]             b_i,
  output logic                               valid_o,
  output logic                               last_o,
  output logic                               mode_o,
  output logic [LANES*2*WIDTH-1:0]           prod_o,
  output logic [2*WIDTH+clog2(LANES)-1:0]    sum_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int SUM_W = PW + clog2(LANES);
  // Leaves padded up to a power of two so the tree is a complete heap.
  localparam int NPAD  = 1 << clog2(LANES);

  logic [LANES*PW-1:0] prod_d;
  logic [SUM_W-1:0]    sum_d;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i*PW +: PW] = {{WIDTH{1'b0}}, a_i[i*WIDTH +: WIDTH]} *
                           {{WIDTH{1'b0}}, b_i[i*WIDTH +: WIDTH]};
    end
  end

  // Heap-ordered adder tree: node 1 is the root, nodes NPAD..2*NPAD-1 are
  // leaves, node n sums children 2n and 2n+1.
  for (genvar n = 1; n < 2 * NPAD; n++) begin : g_node
    logic [SUM_W-1:0] v;
    if (n >= NPAD) begin : g_leaf
      if (n - NPAD < LANES) begin : g_lane
        assign v = SUM_W'(prod_d[(n-NPAD)*PW +: PW]);
      end else begin : g_pad
        assign v = '0;
      end
    end else begin : g_add
      assign v = g_node[2*n].v + g_node[2*n+1].v;
    end
  end

  assign sum_d = g_node[1].v;

  logic                valid_q;
  logic                last_q;
  logic                mode_q;
  logic [LANES*PW-1:0] prod_q;
  logic [SUM_W-1:0]    sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      mode_q  <= MODE_ELEM;
      prod_q  <= '0;
      sum_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      last_q  <= last_i;
      mode_q  <= mode_i;
      prod_q  <= prod_d;
      sum_q   <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign mode_o  = mode_q;
  assign prod_o  = prod_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/elementwise_mac_stream.sv
// elementwise_mac_stream: two-stage streaming multiplier / dot-product unit.
// S1 (lane_product_row) registers per-lane products and their lane sum;
// S2 is the output register. Elementwise packets emit one result per beat;
// dot packets accumulate lane sums and emit one result on the last beat.
//
// Handshake: a beat transfers on a rising edge where valid && ready. The
// whole pipeline advances only when en = !out_valid_o || out_ready_i, and
// in_ready_o = en, so outputs hold stable while out_valid_o && !out_ready_i.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   mode_i           0 elementwise, 1 dot; sampled on a packet's first beat
//   in_valid_i/in_ready_o, in_a_i, in_b_i, in_last_i   input stream
//   out_valid_o/out_ready_i                           output handshake
//   out_data_o       per-lane products (zero for dot results)
//   out_dot_o        packet dot product (zero for elementwise results)
//   out_last_o       beat last (elementwise) or 1 (dot)
//   out_ovf_o        dot accumulator wrapped during the packet
//   dbg_state_o      input-side packet FSM state
module elementwise_mac_stream
  import elementwise_mac_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 8,
  parameter int ACC_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [LANES*WIDTH-1:0]     in_a_i,
  input  logic [LANES*WIDTH-1:0]     in_b_i,
  input  logic                       in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [LANES*2*WIDTH-1:0]   out_data_o,
  output logic [ACC_W-1:0]           out_dot_o,
  output logic                       out_last_o,
  output logic                       out_ovf_o,
  output state_e                     dbg_state_o
);

  localparam int SUM_W = 2 * WIDTH + clog2(LANES);
  // The addition is done wide enough that both an accumulator carry and a
  // lane sum that does not itself fit into ACC_W are seen as a wrap.
  localparam int EXT_W = (ACC_W >= SUM_W) ? ACC_W + 1 : SUM_W + 1;

  logic en;
  logic accept;
  logic out_valid_q;

  assign en         = !out_valid_q || out_ready_i;
  assign in_ready_o = en;
  assign accept     = in_valid_i && en;

  // ---------------- packet FSM (input side) ----------------
  state_e state_q;
  logic   pkt_mode_q;
  logic   beat_mode;

  // The first beat of a packet takes the live mode input; later beats
  // inherit the mode latched on that first beat.
  assign beat_mode = (state_q == ST_IDLE) ? mode_i : pkt_mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pkt_mode_q <= MODE_ELEM;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          pkt_mode_q <= mode_i;
          state_q    <= in_last_i ? ST_IDLE : ST_ACCUM;
        end
        ST_ACCUM: begin
          if (in_last_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

  // ---------------- stage S1 ----------------
  logic                       s1_valid;
  logic                       s1_last;
  logic                       s1_mode;
  logic [LANES*2*WIDTH-1:0]   s1_prod;
  logic [SUM_W-1:0]           s1_sum;

  lane_product_row #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .valid_i (in_valid_i),
    .last_i  (in_last_i),
    .mode_i  (beat_mode),
    .a_i     (in_a_i),
    .b_i     (in_b_i),
    .valid_o (s1_valid),
    .last_o  (s1_last),
    .mode_o  (s1_mode),
    .prod_o  (s1_prod),
    .sum_o   (s1_sum)
  );

  // ---------------- accumulator and stage S2 ----------------
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic [EXT_W-1:0]         acc_sum;
  logic [ACC_W-1:0]         acc_next;
  logic                     carry;

  assign acc_sum  = EXT_W'(acc_q) + EXT_W'(s1_sum);
  assign acc_next = acc_sum[ACC_W-1:0];
  assign carry    = |acc_sum[EXT_W-1:ACC_W];

  logic                       out_valid_d;
  logic [LANES*2*WIDTH-1:0]   out_data_q, out_data_d;
  logic [ACC_W-1:0]           out_dot_q, out_dot_d;
  logic                       out_last_q, out_last_d;
  logic                       out_ovf_q, out_ovf_d;

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dot_d   = out_dot_q;
    out_last_d  = out_last_q;
    out_ovf_d   = out_ovf_q;
    if (en) begin
      // Current output (if any) is being consumed; refill or go empty.
      out_valid_d = 1'b0;
      if (s1_valid) begin
        if (s1_mode == MODE_ELEM) begin
          out_valid_d = 1'b1;
          out_data_d  = s1_prod;
          out_dot_d   = '0;
          out_last_d  = s1_last;
          out_ovf_d   = 1'b0;
        end else if (s1_last) begin
          out_valid_d = 1'b1;
          out_data_d  = '0;
          out_dot_d   = acc_next;
          out_last_d  = 1'b1;
          out_ovf_d   = ovf_q | carry;
          // Clearing here lets the next packet's first beat add onto zero.
          acc_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = acc_next;
          ovf_d = ovf_q | carry;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dot_q   <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dot_q   <= out_dot_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_dot_o   = out_dot_q;
  assign out_last_o  = out_last_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_elementwise_mac_stream.sv
// Bench for elementwise_mac_stream: two instances (ACC_W=32 and ACC_W=16)
// share one input stream; a packet-level reference model fills exp_q and a
// negedge monitor pops it on every output transfer.
module tb_elementwise_mac_stream;
  import elementwise_mac_stream_pkg::*;

  localparam int W  = 8;
  localparam int L  = 8;
  localparam int IW = L * W;
  localparam int DW = L * 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [IW-1:0] in_a = '0;
  logic [IW-1:0] in_b = '0;

  logic          in_ready32, out_valid32, out_last32, out_ovf32;
  logic [DW-1:0] out_data32;
  logic [31:0]   out_dot32;
  state_e        state32;
  logic          in_ready16, out_valid16, out_last16, out_ovf16;
  logic [DW-1:0] out_data16;
  logic [15:0]   out_dot16;
  state_e        state16;

  elementwise_mac_stream #(.WIDTH(W), .LANES(L), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .in_valid_i(in_valid),
    .in_ready_o(in_ready32), .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .out_valid_o(out_valid32), .out_ready_i(out_ready), .out_data_o(out_data32),
    .out_dot_o(out_dot32), .out_last_o(out_last32), .out_ovf_o(out_ovf32),
    .dbg_state_o(state32)
  );

  elementwise_mac_stream #(.WIDTH(W), .LANES(L), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .in_valid_i(in_valid),
    .in_ready_o(in_ready16), .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .out_valid_o(out_valid16), .out_ready_i(out_ready), .out_data_o(out_data16),
    .out_dot_o(out_dot16), .out_last_o(out_last16), .out_ovf_o(out_ovf16),
    .dbg_state_o(state16)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   dot32;
    logic [15:0]   dot16;
    logic          last;
    logic          ovf32;
    logic          ovf16;
  } exp_t;

  exp_t exp_q[$];
  bit              m_in_pkt = 1'b0;
  bit              m_mode   = 1'b0;
  longint unsigned m_sum    = 0;

  task automatic model_accept(input logic md, input logic [IW-1:0] a,
                              input logic [IW-1:0] b, input logic lst);
    exp_t e;
    longint unsigned lane_sum;
    int p;
    lane_sum = 0;
    if (!m_in_pkt) begin
      m_mode = md;
      m_sum  = 0;
    end
    e.data = '0; e.dot32 = '0; e.dot16 = '0; e.last = lst; e.ovf32 = 1'b0; e.ovf16 = 1'b0;
    for (int i = 0; i < L; i++) begin
      p = int'(a[i*W +: W]) * int'(b[i*W +: W]);
      e.data[i*2*W +: 2*W] = 16'(p);
      lane_sum += longint'(p);
    end
    if (m_mode == 1'b0) begin
      exp_q.push_back(e);
    end else begin
      m_sum += lane_sum;
      if (lst) begin
        e.data  = '0;
        e.last  = 1'b1;
        e.dot32 = m_sum[31:0];
        e.ovf32 = (m_sum >= 64'h1_0000_0000);
        e.dot16 = m_sum[15:0];
        e.ovf16 = (m_sum >= 64'h1_0000);
        exp_q.push_back(e);
      end
    end
    m_in_pkt = !lst;
  endtask

  // ---------------- out_ready driver ----------------
  int rdy_mode = 0;
  int rdy_cnt  = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        out_ready = (rdy_cnt % 3 == 0);
        rdy_cnt++;
      end
    endcase
  end

  // ---------------- monitor ----------------
  int            n_out = 0;
  bit            stalled = 1'b0;
  logic [DW-1:0] hold_data;
  logic [31:0]   hold_dot;
  logic          hold_last, hold_ovf;
  logic [DW-1:0] last_data;
  logic [31:0]   last_dot32;
  logic [15:0]   last_dot16;
  logic          last_ovf32, last_ovf16;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (out_valid32 && !out_ready) check("in_ready_stall", in_ready32, 1'b0);
      else                           check("in_ready_free", in_ready32, 1'b1);
      if (stalled) begin
        check("stall_valid", out_valid32, 1'b1);
        check("stall_data", out_data32, hold_data);
        check("stall_dot", out_dot32, hold_dot);
        check("stall_last_ovf", {out_last32, out_ovf32}, {hold_last, hold_ovf});
      end
      if ((out_valid32 || out_valid16) && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          check("valid32", out_valid32, 1'b1);
          check("valid16", out_valid16, 1'b1);
          check("data32", out_data32, e.data);
          check("data16", out_data16, e.data);
          check("dot32", out_dot32, e.dot32);
          check("dot16", out_dot16, e.dot16);
          check("last", {out_last32, out_last16}, {e.last, e.last});
          check("ovf32", out_ovf32, e.ovf32);
          check("ovf16", out_ovf16, e.ovf16);
          last_data  = out_data32;
          last_dot32 = out_dot32;
          last_dot16 = out_dot16;
          last_ovf32 = out_ovf32;
          last_ovf16 = out_ovf16;
        end
      end
      stalled   = out_valid32 && !out_ready;
      hold_data = out_data32;
      hold_dot  = out_dot32;
      hold_last = out_last32;
      hold_ovf  = out_ovf32;
    end
  end

  // ---------------- input driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic send(input logic md, input logic [IW-1:0] a,
                      input logic [IW-1:0] b, input logic lst);
    bit done;
    bit rdy;
    int waited;
    done = 1'b0;
    waited = 0;
    mode = md; in_a = a; in_b = b; in_last = lst; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      rdy = in_ready32;
      @(posedge clk);
      if (rdy) begin
        model_accept(md, a, b, lst);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check("in_ready_timeout", 1'b0, 1'b1);
          done = 1'b1;
        end
      end
    end
    #1;
    in_valid = 1'b0;
    mode = 1'($urandom); in_last = 1'($urandom);
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() == 0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {out_valid32, out_valid16}, 2'b00);
    check({tag, "_data"}, out_data32 | out_data16, '0);
    check({tag, "_dot"}, {out_dot32, out_dot16}, '0);
    check({tag, "_last_ovf"}, {out_last32, out_ovf32, out_last16, out_ovf16}, 4'b0);
  endtask

  // ---------------- main sequence ----------------
  logic [IW-1:0] va, vb, vk;
  logic [DW-1:0] exp_t1;
  int            n0;

  initial begin
    for (int i = 0; i < L; i++) begin
      va[i*W +: W]       = W'(i + 1);
      vb[i*W +: W]       = W'(8 - i);
    end
    exp_t1 = {16'd8, 16'd14, 16'd18, 16'd20, 16'd20, 16'd18, 16'd14, 16'd8};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {in_ready32, in_ready16}, 2'b11);
    check("state_after_reset", state32, ST_IDLE);
    @(posedge clk);
    #1;

    // 1: elementwise single beat, latency 2 cycles
    send(MODE_ELEM, va, vb, 1'b1);
    @(negedge clk);
    check("t1_not_yet_valid", out_valid32, 1'b0);
    @(negedge clk);
    check("t1_valid_latency", out_valid32, 1'b1);
    check("t1_products", out_data32, exp_t1);
    check("t1_last", out_last32, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // 2: dot packet of two beats
    n0 = n_out;
    send(MODE_DOT, va, vb, 1'b0);
    send(MODE_DOT, va, vb, 1'b1);
    wait_drain();
    check("t2_one_result", n_out - n0, 1);
    check("t2_dot", last_dot32, 32'd240);
    check("t2_ovf", last_ovf32, 1'b0);

    // 3: backpressure with out_ready 1,0,0,1,...
    rdy_mode = 2;
    n0 = n_out;
    for (int k = 1; k <= 4; k++) begin
      vk = {8{8'(k)}};
      send(MODE_ELEM, vk, vk, 1'b1);
    end
    wait_drain();
    check("t3_four_results", n_out - n0, 4);
    check("t3_last_lanes", last_data, {8{16'd16}});
    rdy_mode = 0;

    // 4: overflow on the 16-bit accumulator, then a clean packet
    send(MODE_DOT, {8{8'hff}}, {8{8'hff}}, 1'b1);
    wait_drain();
    check("t4_dot16", last_dot16, 16'd61448);
    check("t4_ovf16", last_ovf16, 1'b1);
    check("t4_dot32", last_dot32, 32'd520200);
    check("t4_ovf32", last_ovf32, 1'b0);
    send(MODE_DOT, {8{8'h01}}, {8{8'h01}}, 1'b1);
    wait_drain();
    check("t4_follow_dot16", last_dot16, 16'd8);
    check("t4_follow_ovf16", last_ovf16, 1'b0);

    // 5: reset in the middle of a dot packet
    send(MODE_DOT, va, vb, 1'b0);
    idle(2);
    rst_n = 1'b0;
    exp_q.delete();
    m_in_pkt = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(MODE_DOT, va, vb, 1'b1);
    wait_drain();
    check("t5_dot_after_reset", last_dot32, 32'd120);

    // 6: mode input changes on the second beat of a dot packet
    send(MODE_DOT, va, vb, 1'b0);
    send(MODE_ELEM, va, vb, 1'b1);
    wait_drain();
    check("t6_dot", last_dot32, 32'd240);
    check("t6_data_zero", last_data, '0);

    // Random traffic under random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      send(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    // Close any packet left open so its result is flushed.
    send(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    wait_drain();
    rdy_mode = 0;
    idle(4);
    check("no_leftover_expected", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
